// File: rtl/top_res_tbl_cmd_sched.sv
// ----------------------------------------------------------------------------
// top_res_tbl_cmd_sched
//
// Arbitrates alloc and dealloc commands toward the resource table top. It
// issues at most one command per cycle and keeps one "busy" flag per resource
// table group, so a group never has two commands in flight at once.
//
// Dealloc commands are queued in order in a small FIFO. A single alloc can be
// outstanding at a time. Dealloc normally wins arbitration. An eligible alloc
// that keeps losing gains priority once it has lost STARVE_LIMIT cycles.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   alloc_valid_i / alloc_ready_o   alloc handshake (ready is combinational)
//   alloc_cu_id_i, alloc_wg_id_i    alloc target, held until alloc done
//   dealloc_valid_i / dealloc_ready_o  dealloc handshake into the FIFO
//   dealloc_cu_id_i, dealloc_wg_id_i   dealloc target
//   wg_alloc_valid_o                one-cycle alloc issue pulse
//   wg_dealloc_valid_o              one-cycle dealloc issue pulse
//   dealloc_cu_id_o/_wg_id_o        dealloc target, qualified by the pulse
//   grt_wg_*_done_i, grt_wg_*_cu_id_i  completion reports per command type
//   group_busy_o                    per-group outstanding-command flags
//   fifo_count_o                    dealloc FIFO occupancy
//   err_o                           sticky protocol error
// ----------------------------------------------------------------------------
`ifndef CU_ID_WIDTH
`define CU_ID_WIDTH 6
`endif
`ifndef WG_ID_WIDTH
`define WG_ID_WIDTH 15
`endif
`ifndef NUMBER_RES_TABLE
`define NUMBER_RES_TABLE 4
`endif
`ifndef RES_TABLE_ADDR_WIDTH
`define RES_TABLE_ADDR_WIDTH 2
`endif

module top_res_tbl_cmd_sched #(
    parameter int DEALLOC_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    alloc_valid_i,
    output logic                                    alloc_ready_o,
    input  logic [`CU_ID_WIDTH-1:0]                 alloc_cu_id_i,
    input  logic [`WG_ID_WIDTH-1:0]                 alloc_wg_id_i,
    input  logic                                    dealloc_valid_i,
    output logic                                    dealloc_ready_o,
    input  logic [`CU_ID_WIDTH-1:0]                 dealloc_cu_id_i,
    input  logic [`WG_ID_WIDTH-1:0]                 dealloc_wg_id_i,
    output logic                                    wg_alloc_valid_o,
    output logic                                    wg_dealloc_valid_o,
    output logic [`CU_ID_WIDTH-1:0]                 dealloc_cu_id_o,
    output logic [`WG_ID_WIDTH-1:0]                 dealloc_wg_id_o,
    input  logic                                    grt_wg_alloc_done_i,
    input  logic [`CU_ID_WIDTH-1:0]                 grt_wg_alloc_cu_id_i,
    input  logic                                    grt_wg_dealloc_done_i,
    input  logic [`CU_ID_WIDTH-1:0]                 grt_wg_dealloc_cu_id_i,
    output logic [`NUMBER_RES_TABLE-1:0]            group_busy_o,
    output logic [$clog2(DEALLOC_FIFO_DEPTH):0]     fifo_count_o,
    output logic                                    err_o
);
    localparam int CU_W  = `CU_ID_WIDTH;
    localparam int WG_W  = `WG_ID_WIDTH;
    localparam int NGRP  = `NUMBER_RES_TABLE;
    localparam int GRP_W = `RES_TABLE_ADDR_WIDTH;
    localparam int PTR_W = $clog2(DEALLOC_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    // Dealloc FIFO storage. It has no reset because only entries between the
    // pointers are ever read. The head is read combinationally, so eligibility
    // can be decided in the same cycle.
    logic [CU_W-1:0] fifo_cu_mem [DEALLOC_FIFO_DEPTH];
    logic [WG_W-1:0] fifo_wg_mem [DEALLOC_FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [NGRP-1:0]  group_busy_reg, group_busy_next;
    logic             alloc_pending_reg, alloc_pending_next;
    logic [STV_W-1:0] starve_reg, starve_next;
    logic             err_reg, err_next;
    logic             wg_alloc_valid_reg, wg_dealloc_valid_reg;
    logic [CU_W-1:0]  dealloc_cu_id_reg;
    logic [WG_W-1:0]  dealloc_wg_id_reg;

    // The group of a CU is the top bits of its id.
    logic [CU_W-1:0]  head_cu;
    logic [WG_W-1:0]  head_wg;
    logic [GRP_W-1:0] alloc_grp, head_grp, ad_grp, dd_grp;

    assign head_cu   = fifo_cu_mem[rd_ptr_reg];
    assign head_wg   = fifo_wg_mem[rd_ptr_reg];
    assign alloc_grp = alloc_cu_id_i[CU_W-1 -: GRP_W];
    assign head_grp  = head_cu[CU_W-1 -: GRP_W];
    assign ad_grp    = grt_wg_alloc_cu_id_i[CU_W-1 -: GRP_W];
    assign dd_grp    = grt_wg_dealloc_cu_id_i[CU_W-1 -: GRP_W];

    logic fifo_full, fifo_empty, push, pop;
    logic alloc_elig, dealloc_elig, sel_alloc, sel_dealloc;
    logic alloc_done_hit, dealloc_done_hit;
    logic [NGRP-1:0] busy_set, busy_clr;

    assign fifo_full  = (count_reg == CNT_W'(DEALLOC_FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);

    // Eligibility looks only at the registered busy flags. A group that is
    // being released this cycle can therefore be picked next cycle at the
    // earliest.
    assign alloc_elig   = alloc_valid_i && !alloc_pending_reg && !group_busy_reg[alloc_grp];
    assign dealloc_elig = !fifo_empty && !group_busy_reg[head_grp];
    assign sel_alloc    = alloc_elig && (!dealloc_elig || starve_reg == STV_W'(STARVE_LIMIT));
    assign sel_dealloc  = dealloc_elig && !sel_alloc;

    assign push = dealloc_valid_i && !fifo_full;
    assign pop  = sel_dealloc;

    // A completion counts only if it matches something outstanding. An
    // unmatched completion changes nothing except the error flag.
    assign alloc_done_hit   = grt_wg_alloc_done_i && alloc_pending_reg && group_busy_reg[ad_grp];
    assign dealloc_done_hit = grt_wg_dealloc_done_i && group_busy_reg[dd_grp];

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_busy
        assign busy_set[gi] = (sel_alloc && alloc_grp == GRP_W'(gi)) ||
                              (sel_dealloc && head_grp == GRP_W'(gi));
        assign busy_clr[gi] = (alloc_done_hit && ad_grp == GRP_W'(gi)) ||
                              (dealloc_done_hit && dd_grp == GRP_W'(gi));
    end

    always_comb begin
        wr_ptr_next        = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next        = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next         = count_reg;
        if (push && !pop) count_next = count_reg + 1'b1;
        if (pop && !push) count_next = count_reg - 1'b1;
        // Selection requires a clear bit and a done requires a set bit, so
        // the set and clear terms never refer to the same group.
        group_busy_next    = (group_busy_reg & ~busy_clr) | busy_set;
        alloc_pending_next = alloc_pending_reg;
        if (alloc_done_hit) alloc_pending_next = 1'b0;
        if (sel_alloc)      alloc_pending_next = 1'b1;
        starve_next        = starve_reg;
        if (!alloc_valid_i || sel_alloc)
            starve_next = '0;
        else if (alloc_elig && starve_reg != STV_W'(STARVE_LIMIT))
            starve_next = starve_reg + 1'b1;
        err_next = err_reg ||
                   (grt_wg_alloc_done_i && !alloc_done_hit) ||
                   (grt_wg_dealloc_done_i && !dealloc_done_hit);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cu_mem[wr_ptr_reg] <= dealloc_cu_id_i;
            fifo_wg_mem[wr_ptr_reg] <= dealloc_wg_id_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg           <= '0;
            rd_ptr_reg           <= '0;
            count_reg            <= '0;
            group_busy_reg       <= '0;
            alloc_pending_reg    <= 1'b0;
            starve_reg           <= '0;
            err_reg              <= 1'b0;
            wg_alloc_valid_reg   <= 1'b0;
            wg_dealloc_valid_reg <= 1'b0;
            dealloc_cu_id_reg    <= '0;
            dealloc_wg_id_reg    <= '0;
        end else begin
            wr_ptr_reg           <= wr_ptr_next;
            rd_ptr_reg           <= rd_ptr_next;
            count_reg            <= count_next;
            group_busy_reg       <= group_busy_next;
            alloc_pending_reg    <= alloc_pending_next;
            starve_reg           <= starve_next;
            err_reg              <= err_next;
            wg_alloc_valid_reg   <= sel_alloc;
            wg_dealloc_valid_reg <= sel_dealloc;
            if (sel_dealloc) begin
                dealloc_cu_id_reg <= head_cu;
                dealloc_wg_id_reg <= head_wg;
            end
        end
    end

    assign alloc_ready_o      = sel_alloc;
    assign dealloc_ready_o    = !fifo_full;
    assign wg_alloc_valid_o   = wg_alloc_valid_reg;
    assign wg_dealloc_valid_o = wg_dealloc_valid_reg;
    assign dealloc_cu_id_o    = dealloc_cu_id_reg;
    assign dealloc_wg_id_o    = dealloc_wg_id_reg;
    assign group_busy_o       = group_busy_reg;
    assign fifo_count_o       = count_reg;
    assign err_o              = err_reg;

endmodule

// File: tb/tb_top_res_tbl_cmd_sched.sv
// ----------------------------------------------------------------------------
// tb_top_res_tbl_cmd_sched
//
// Directed bench for top_res_tbl_cmd_sched with hand-computed expectations.
// Inputs change 1 ns after the rising edge. Outputs are checked 1-2 ns after
// the edge, well away from the next rising edge.
// Group mapping with the default widths: cu 0-15 -> g0, 16-31 -> g1,
// 32-47 -> g2, 48-63 -> g3.
// ----------------------------------------------------------------------------
`ifndef CU_ID_WIDTH
`define CU_ID_WIDTH 6
`endif
`ifndef WG_ID_WIDTH
`define WG_ID_WIDTH 15
`endif
`ifndef NUMBER_RES_TABLE
`define NUMBER_RES_TABLE 4
`endif
`ifndef RES_TABLE_ADDR_WIDTH
`define RES_TABLE_ADDR_WIDTH 2
`endif

module tb_top_res_tbl_cmd_sched;
    logic clk = 1'b0;
    logic rst_n;
    logic alloc_valid_i, alloc_ready_o;
    logic [`CU_ID_WIDTH-1:0] alloc_cu_id_i;
    logic [`WG_ID_WIDTH-1:0] alloc_wg_id_i;
    logic dealloc_valid_i, dealloc_ready_o;
    logic [`CU_ID_WIDTH-1:0] dealloc_cu_id_i;
    logic [`WG_ID_WIDTH-1:0] dealloc_wg_id_i;
    logic wg_alloc_valid_o, wg_dealloc_valid_o;
    logic [`CU_ID_WIDTH-1:0] dealloc_cu_id_o;
    logic [`WG_ID_WIDTH-1:0] dealloc_wg_id_o;
    logic grt_wg_alloc_done_i, grt_wg_dealloc_done_i;
    logic [`CU_ID_WIDTH-1:0] grt_wg_alloc_cu_id_i, grt_wg_dealloc_cu_id_i;
    logic [`NUMBER_RES_TABLE-1:0] group_busy_o;
    logic [2:0] fifo_count_o;
    logic err_o;

    int n_vec = 0;
    int n_mis = 0;

    top_res_tbl_cmd_sched #(.DEALLOC_FIFO_DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_cu_id_i(alloc_cu_id_i), .alloc_wg_id_i(alloc_wg_id_i),
        .dealloc_valid_i(dealloc_valid_i), .dealloc_ready_o(dealloc_ready_o),
        .dealloc_cu_id_i(dealloc_cu_id_i), .dealloc_wg_id_i(dealloc_wg_id_i),
        .wg_alloc_valid_o(wg_alloc_valid_o), .wg_dealloc_valid_o(wg_dealloc_valid_o),
        .dealloc_cu_id_o(dealloc_cu_id_o), .dealloc_wg_id_o(dealloc_wg_id_o),
        .grt_wg_alloc_done_i(grt_wg_alloc_done_i), .grt_wg_alloc_cu_id_i(grt_wg_alloc_cu_id_i),
        .grt_wg_dealloc_done_i(grt_wg_dealloc_done_i), .grt_wg_dealloc_cu_id_i(grt_wg_dealloc_cu_id_i),
        .group_busy_o(group_busy_o), .fifo_count_o(fifo_count_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid_i = 0; alloc_cu_id_i = '0; alloc_wg_id_i = '0;
        dealloc_valid_i = 0; dealloc_cu_id_i = '0; dealloc_wg_id_i = '0;
        grt_wg_alloc_done_i = 0; grt_wg_alloc_cu_id_i = '0;
        grt_wg_dealloc_done_i = 0; grt_wg_dealloc_cu_id_i = '0;
        repeat (3) tick();

        // Reset state
        check_vec("rst_alloc_valid", wg_alloc_valid_o, 0);
        check_vec("rst_dealloc_valid", wg_dealloc_valid_o, 0);
        check_vec("rst_dealloc_ready", dealloc_ready_o, 1);
        check_vec("rst_alloc_ready", alloc_ready_o, 0);
        check_vec("rst_fifo_count", fifo_count_o, 0);
        check_vec("rst_busy", group_busy_o, 0);
        check_vec("rst_err", err_o, 0);
        check_vec("rst_dealloc_cu", dealloc_cu_id_o, 0);
        rst_n = 1'b1;
        tick();

        // Single alloc to cu 0
        alloc_valid_i = 1; alloc_cu_id_i = 0; alloc_wg_id_i = 5;
        #1 check_vec("t1_alloc_ready", alloc_ready_o, 1);
        tick();
        check_vec("t1_alloc_pulse", wg_alloc_valid_o, 1);
        check_vec("t1_busy_set", group_busy_o, 1);
        alloc_valid_i = 0;
        #1 check_vec("t1_ready_drop", alloc_ready_o, 0);
        tick();
        check_vec("t1_pulse_end", wg_alloc_valid_o, 0);
        check_vec("t1_busy_held", group_busy_o, 1);
        grt_wg_alloc_done_i = 1; grt_wg_alloc_cu_id_i = 0;
        #1 check_vec("t1_busy_in_done_cyc", group_busy_o, 1);
        tick();
        grt_wg_alloc_done_i = 0;
        check_vec("t1_busy_clear", group_busy_o, 0);
        check_vec("t1_err", err_o, 0);

        // Five deallocs into a depth-4 FIFO while group 0 is busy
        alloc_valid_i = 1; alloc_cu_id_i = 0;
        tick();
        alloc_valid_i = 0;
        check_vec("t2_busy", group_busy_o, 1);
        for (int k = 0; k < 5; k++) begin
            dealloc_valid_i = 1; dealloc_cu_id_i = 6'(k + 1); dealloc_wg_id_i = 15'(10 + k);
            #1 check_vec($sformatf("t2_ready_%0d", k), dealloc_ready_o, (k < 4) ? 1 : 0);
            tick();
        end
        dealloc_valid_i = 0;
        check_vec("t2_fifo_full", fifo_count_o, 4);
        grt_wg_alloc_done_i = 1; grt_wg_alloc_cu_id_i = 0;
        tick();
        grt_wg_alloc_done_i = 0;
        check_vec("t2_busy_free", group_busy_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_vec($sformatf("t2_issue_%0d", i), wg_dealloc_valid_o, 1);
            check_vec($sformatf("t2_cu_%0d", i), dealloc_cu_id_o, i + 1);
            check_vec($sformatf("t2_wg_%0d", i), dealloc_wg_id_o, 10 + i);
            grt_wg_dealloc_done_i = 1; grt_wg_dealloc_cu_id_i = 0;
            tick();
            grt_wg_dealloc_done_i = 0;
        end
        check_vec("t2_fifo_empty", fifo_count_o, 0);
        check_vec("t2_busy_end", group_busy_o, 0);
        check_vec("t2_no_pulse", wg_dealloc_valid_o, 0);

        // Alloc (g0) and dealloc (g1) both eligible: dealloc goes first
        dealloc_valid_i = 1; dealloc_cu_id_i = 16; dealloc_wg_id_i = 7;
        tick();
        dealloc_valid_i = 0;
        alloc_valid_i = 1; alloc_cu_id_i = 0; alloc_wg_id_i = 9;
        #1 check_vec("t3_alloc_loses", alloc_ready_o, 0);
        tick();
        check_vec("t3_dealloc_first", wg_dealloc_valid_o, 1);
        check_vec("t3_dealloc_cu", dealloc_cu_id_o, 16);
        check_vec("t3_no_alloc_yet", wg_alloc_valid_o, 0);
        check_vec("t3_busy_g1", group_busy_o, 2);
        check_vec("t3_alloc_ready", alloc_ready_o, 1);
        tick();
        check_vec("t3_alloc_next", wg_alloc_valid_o, 1);
        check_vec("t3_busy_g01", group_busy_o, 3);
        alloc_valid_i = 0;

        // Alloc done and dealloc done in the same cycle, then a spurious done
        grt_wg_alloc_done_i = 1; grt_wg_alloc_cu_id_i = 0;
        grt_wg_dealloc_done_i = 1; grt_wg_dealloc_cu_id_i = 16;
        tick();
        grt_wg_alloc_done_i = 0; grt_wg_dealloc_done_i = 0;
        check_vec("t3_both_clear", group_busy_o, 0);
        check_vec("t3_err_clean", err_o, 0);
        grt_wg_dealloc_done_i = 1; grt_wg_dealloc_cu_id_i = 48;
        tick();
        grt_wg_dealloc_done_i = 0;
        check_vec("t3_err_set", err_o, 1);
        check_vec("t3_busy_unchanged", group_busy_o, 0);
        tick();
        check_vec("t3_err_sticky", err_o, 1);

        // Starvation: alloc loses four cycles, then wins the fifth
        alloc_valid_i = 1; alloc_cu_id_i = 16; alloc_wg_id_i = 3;
        tick();
        alloc_valid_i = 0;
        check_vec("t4_busy_g1", group_busy_o, 2);
        for (int k = 0; k < 4; k++) begin
            dealloc_valid_i = 1;
            dealloc_cu_id_i = (k == 0) ? 6'd16 : (k == 1) ? 6'd32 : (k == 2) ? 6'd48 : 6'd17;
            dealloc_wg_id_i = 15'(20 + k);
            tick();
        end
        dealloc_valid_i = 0;
        check_vec("t4_preload", fifo_count_o, 4);
        // C0: alloc done frees g1; the new alloc is still blocked by pending
        grt_wg_alloc_done_i = 1; grt_wg_alloc_cu_id_i = 16;
        alloc_valid_i = 1; alloc_cu_id_i = 0; alloc_wg_id_i = 30;
        #1 check_vec("t4_c0_ready", alloc_ready_o, 0);
        tick();
        grt_wg_alloc_done_i = 0;
        #1 check_vec("t4_c1_ready", alloc_ready_o, 0);
        tick();
        check_vec("t4_c1_issue", dealloc_cu_id_o, 16);
        grt_wg_dealloc_done_i = 1; grt_wg_dealloc_cu_id_i = 16;
        dealloc_valid_i = 1; dealloc_cu_id_i = 33; dealloc_wg_id_i = 24;
        #1 check_vec("t4_c2_ready", alloc_ready_o, 0);
        check_vec("t4_c2_dready", dealloc_ready_o, 1);
        tick();
        check_vec("t4_c2_issue", dealloc_cu_id_o, 32);
        check_vec("t4_push_pop", fifo_count_o, 3);
        dealloc_valid_i = 0;
        grt_wg_dealloc_done_i = 1; grt_wg_dealloc_cu_id_i = 32;
        #1 check_vec("t4_c3_ready", alloc_ready_o, 0);
        tick();
        check_vec("t4_c3_issue", dealloc_cu_id_o, 48);
        grt_wg_dealloc_done_i = 0;
        #1 check_vec("t4_c4_ready", alloc_ready_o, 0);
        tick();
        check_vec("t4_c4_issue", dealloc_cu_id_o, 17);
        #1 check_vec("t4_c5_alloc_wins", alloc_ready_o, 1);
        tick();
        check_vec("t4_alloc_pulse", wg_alloc_valid_o, 1);
        check_vec("t4_no_dealloc", wg_dealloc_valid_o, 0);
        alloc_valid_i = 0;
        tick();
        check_vec("t4_c6_dealloc", wg_dealloc_valid_o, 1);
        check_vec("t4_c6_cu", dealloc_cu_id_o, 33);
        check_vec("t4_c6_wg", dealloc_wg_id_o, 24);
        check_vec("t4_c6_fifo", fifo_count_o, 0);

        // Reset while busy with two queued deallocs
        dealloc_valid_i = 1; dealloc_cu_id_i = 1; dealloc_wg_id_i = 40;
        tick();
        dealloc_cu_id_i = 2; dealloc_wg_id_i = 41;
        tick();
        dealloc_valid_i = 0;
        check_vec("t5_queued", fifo_count_o, 2);
        check_vec("t5_busy_all", group_busy_o, 15);
        rst_n = 1'b0;
        #1;
        check_vec("t5_rst_fifo", fifo_count_o, 0);
        check_vec("t5_rst_busy", group_busy_o, 0);
        check_vec("t5_rst_err", err_o, 0);
        check_vec("t5_rst_dready", dealloc_ready_o, 1);
        check_vec("t5_rst_aval", wg_alloc_valid_o, 0);
        check_vec("t5_rst_dval", wg_dealloc_valid_o, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_vec($sformatf("t5_quiet_d%0d", k), wg_dealloc_valid_o, 0);
            check_vec($sformatf("t5_quiet_a%0d", k), wg_alloc_valid_o, 0);
        end
        check_vec("t5_fifo_after", fifo_count_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/top_res_tbl_cmd_sched.md
TOP_RES_TBL_CMD_SCHED -- requirements
Module: top_res_tbl_cmd_sched

Interface
REQ-001 Parameter DEALLOC_FIFO_DEPTH, default 4, dealloc command FIFO entries (power of 2, >=2).
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive cycles an eligible alloc may lose arbitration before it gains priority.
REQ-003 Widths SHALL come from define.v: `CU_ID_WIDTH, `WG_ID_WIDTH, `NUMBER_RES_TABLE, `RES_TABLE_ADDR_WIDTH.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 alloc_valid_i / alloc_ready_o  in/out  1/1  alloc command handshake from allocator.
REQ-007 alloc_cu_id_i, alloc_wg_id_i  in  `CU_ID_WIDTH, `WG_ID_WIDTH  alloc target; allocator holds these and vgpr/sgpr/lds fields stable until grt_wg_alloc_done_i.
REQ-008 dealloc_valid_i / dealloc_ready_o  in/out  1/1  dealloc command handshake from gpu interface.
REQ-009 dealloc_cu_id_i, dealloc_wg_id_i  in  `CU_ID_WIDTH, `WG_ID_WIDTH  dealloc target.
REQ-010 wg_alloc_valid_o, wg_dealloc_valid_o  out  1 each  one-cycle issue pulses to resource table top.
REQ-011 dealloc_cu_id_o, dealloc_wg_id_o  out  `CU_ID_WIDTH, `WG_ID_WIDTH  dealloc target, valid with wg_dealloc_valid_o.
REQ-012 grt_wg_alloc_done_i, grt_wg_alloc_cu_id_i, grt_wg_dealloc_done_i, grt_wg_dealloc_cu_id_i  in  1, `CU_ID_WIDTH, 1, `CU_ID_WIDTH  completion reports.
REQ-013 group_busy_o  out  `NUMBER_RES_TABLE  per-group outstanding-command flags.
REQ-014 fifo_count_o  out  clog2(DEALLOC_FIFO_DEPTH)+1  dealloc FIFO occupancy.
REQ-015 err_o  out  1  sticky protocol error.

Function
REQ-016 Group index of a cu_id SHALL be its top `RES_TABLE_ADDR_WIDTH bits.
REQ-017 Dealloc FIFO: dealloc_ready_o = !full (no bypass); push on valid&&ready; pop on dealloc issue; push+pop same cycle keeps count.
REQ-018 Alloc eligible: alloc_valid_i && !alloc_pending && !group_busy[grp(alloc_cu_id_i)]; alloc_pending set on alloc issue, cleared on grt_wg_alloc_done_i.
REQ-019 Dealloc eligible: FIFO non-empty && !group_busy[grp(head cu_id)]; strict in-order, head-of-line blocking accepted.
REQ-020 At most one command issued per cycle; eligibility uses registered group_busy only.
REQ-021 Priority: dealloc over alloc, except alloc wins when starve_cnt == STARVE_LIMIT.
REQ-022 starve_cnt: +1 per cycle alloc eligible but not issued, saturating at STARVE_LIMIT; cleared on alloc issue or alloc_valid_i low.
REQ-023 alloc_ready_o SHALL be combinational, high only in the cycle alloc is selected.
REQ-024 Issue latency: selection in cycle t -> wg_*_valid_o high exactly cycle t+1 with registered ids; group_busy bit set at same edge.
REQ-025 Done for group g clears group_busy[g] at next edge; alloc done and dealloc done in same cycle both apply.
REQ-026 Done clearing group g and selection of g cannot coincide (busy still set); earliest reissue is cycle after clear.
REQ-027 Done for a non-busy group, or alloc done with alloc_pending low: no state change except err_o set.
REQ-028 err_o sticky until reset.

Reset
REQ-029 On rst_n low: all outputs 0, except dealloc_ready_o = 1 (alloc_ready_o combinational, 0 while no eligible request); FIFO empty, group_busy 0, alloc_pending 0, starve_cnt 0, err_o 0.
REQ-030 Reset mid-operation discards queued and outstanding commands; no pulse emitted after release until new requests.

Verification
REQ-031 Single alloc cu 0 (group 0) cycle 0 -> alloc_ready_o cycle 0, wg_alloc_valid_o cycle 1, group_busy_o[0]=1 until cycle after alloc done.
REQ-032 Five deallocs back-to-back, depth 4, groups busy -> dealloc_ready_o low on 5th, fifo_count_o=4; after done, issued in arrival order.
REQ-033 Alloc and dealloc both eligible, different groups -> dealloc issued first; alloc issued cycle after.
REQ-034 Dealloc stream keeps alloc losing 4 cycles -> 5th selection issues alloc.
REQ-035 Alloc done and dealloc done same cycle, groups 0 and 1 -> both busy bits 0 next cycle; spurious done for idle group -> err_o=1.
REQ-036 Reset asserted while group busy with 2 queued deallocs -> outputs cleared, fifo_count_o=0, no issue after release.
